// File: rtl/adc_serial_tx_if.sv
// Sample handshake between a parallel sample source and adc_serial_tx.
// The master drives sample_in/sample_valid; the serialiser answers with sample_ready.
interface adc_serial_tx_if #(
    parameter int unsigned WIDTH = 12
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/adc_serial_tx.sv
// ADC serial output emulator: MSB-first data lane plus frame marker, continuous words.
// Optional ramp source enabled by defining ADC_SERIAL_TX_TEST_PATTERN_EN (selected with test_mode).
module adc_serial_tx #(
    parameter int unsigned     WIDTH      = 12,
    parameter int unsigned     FRAME_HIGH = 6,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic                clk,
    input  logic                RESET_n,
    input  logic                enable,
    input  logic                test_mode,
    adc_serial_tx_if.slave      smp,
    output logic                adc_data,
    output logic                adc_frame,
    output logic                word_strobe,
    output logic                busy,
    output logic [7:0]          underrun_count
);
    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] word, word_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [7:0]       under_n;
    logic             data_n, frame_n, strobe_n, busy_n;
    logic             load, ready, xfer;

`ifdef ADC_SERIAL_TX_TEST_PATTERN_EN
    logic [WIDTH-1:0] ramp, ramp_n;
    assign ready = ~hold_full & ~test_mode;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign ready = ~hold_full;
`endif

    assign smp.sample_ready = ready;
    assign xfer             = smp.sample_valid & ready;

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        word_n      = word;
        hold_n      = hold;
        hold_full_n = hold_full;
        under_n     = underrun_count;
        load        = 1'b0;
        data_n      = 1'b0;
        frame_n     = 1'b0;
        strobe_n    = 1'b0;
        busy_n      = 1'b0;
`ifdef ADC_SERIAL_TX_TEST_PATTERN_EN
        ramp_n      = ramp;
`endif

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    if (enable) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n  = cnt + CW'(1);
                    word_n = word << 1;
                end
            end
            default: state_n = IDLE;
        endcase

        // word holds the remaining bits with the bit on the wire at the MSB
        if (load) begin
            cnt_n = '0;
`ifdef ADC_SERIAL_TX_TEST_PATTERN_EN
            if (test_mode) begin
                word_n = ramp;
                ramp_n = ramp + WIDTH'(1);
            end else
`endif
            if (hold_full) begin
                word_n      = hold;
                hold_full_n = 1'b0;
            end else if (xfer) begin
                word_n = smp.sample_in;
            end else begin
                word_n = IDLE_WORD;
                if (underrun_count != 8'hFF) begin
                    under_n = underrun_count + 8'd1;
                end
            end
        end

        // A transfer on a load edge is always a bypass, since it needs an empty hold.
        if (xfer && !load) begin
            hold_n      = smp.sample_in;
            hold_full_n = 1'b1;
        end

        if (state_n == RUN) begin
            busy_n   = 1'b1;
            data_n   = word_n[WIDTH-1];
            frame_n  = (32'(cnt_n) < FRAME_HIGH);
            strobe_n = (cnt_n == '0);
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt            <= '0;
            word           <= '0;
            hold           <= '0;
            hold_full      <= 1'b0;
            underrun_count <= '0;
            adc_data       <= 1'b0;
            adc_frame      <= 1'b0;
            word_strobe    <= 1'b0;
            busy           <= 1'b0;
`ifdef ADC_SERIAL_TX_TEST_PATTERN_EN
            ramp           <= '0;
`endif
        end else begin
            cnt            <= cnt_n;
            word           <= word_n;
            hold           <= hold_n;
            hold_full      <= hold_full_n;
            underrun_count <= under_n;
            adc_data       <= data_n;
            adc_frame      <= frame_n;
            word_strobe    <= strobe_n;
            busy           <= busy_n;
`ifdef ADC_SERIAL_TX_TEST_PATTERN_EN
            ramp           <= ramp_n;
`endif
        end
    end
endmodule

// File: tb/tb_adc_serial_tx.sv
// Bench for adc_serial_tx: vector table, corner-case sequences and a randomized run
// compared against a word/position level reference model.
module tb_adc_serial_tx;
    localparam int unsigned W      = 12;
    localparam logic [11:0] IDLE_W = 12'h000;

    logic       clk       = 1'b0;
    logic       RESET_n   = 1'b0;
    logic       enable    = 1'b0;
    logic       test_mode = 1'b0;
    logic       adc_data, adc_frame, word_strobe, busy;
    logic [7:0] underrun_count;

    adc_serial_tx_if #(.WIDTH(W)) smp();

    adc_serial_tx #(
        .WIDTH      (W),
        .FRAME_HIGH (6),
        .IDLE_WORD  (IDLE_W)
    ) dut (
        .clk            (clk),
        .RESET_n        (RESET_n),
        .enable         (enable),
        .test_mode      (test_mode),
        .smp            (smp),
        .adc_data       (adc_data),
        .adc_frame      (adc_frame),
        .word_strobe    (word_strobe),
        .busy           (busy),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: streaming state at word/position granularity
    bit          m_run;
    int unsigned m_pos;
    logic [11:0] m_word;
    logic [11:0] m_hold[$];
    int unsigned m_under;

    function automatic void model_reset();
        m_run   = 1'b0;
        m_pos   = 0;
        m_word  = '0;
        m_hold.delete();
        m_under = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit valid, input logic [11:0] din);
        bit rdy;
        bit xfer;
        bit load;
        rdy  = (m_hold.size() == 0);
        xfer = valid && rdy;
        load = en && (!m_run || m_pos == W - 1);
        if (m_run && m_pos == W - 1 && !en) begin
            m_run = 1'b0;
        end else if (load) begin
            m_run = 1'b1;
            m_pos = 0;
            if (m_hold.size() > 0) m_word = m_hold.pop_front();
            else if (xfer)         m_word = din;
            else begin
                m_word = IDLE_W;
                if (m_under < 255) m_under++;
            end
        end else if (m_run) begin
            m_pos++;
        end
        if (xfer && !load) m_hold.push_back(din);
    endfunction

    function automatic logic [12:0] model_vec();
        logic d, f, s, b;
        d = 1'b0; f = 1'b0; s = 1'b0; b = 1'b0;
        if (m_run) begin
            d = ((m_word >> (W - 1 - m_pos)) & 12'd1) != 12'd0;
            f = m_pos < 6;
            s = m_pos == 0;
            b = 1'b1;
        end
        return {d, f, s, b, (m_hold.size() == 0), 8'(m_under)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {adc_data, adc_frame, word_strobe, busy, smp.sample_ready, underrun_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input bit valid, input logic [11:0] din);
        enable           = en;
        smp.sample_valid = valid;
        smp.sample_in    = din;
        @(posedge clk);
        model_edge(en, valid, din);
        #1;
    endtask

    task automatic do_reset();
        RESET_n          = 1'b0;
        enable           = 1'b0;
        smp.sample_valid = 1'b0;
        #1;
        model_reset();
        check("reset_state", 32'(dut_vec()), 32'(13'b0000_1_00000000));
        @(posedge clk);
        #1;
        RESET_n = 1'b1;
    endtask

    typedef struct {
        bit          en;
        bit          valid;
        logic [11:0] din;
        logic [4:0]  exp;   // {adc_data, adc_frame, word_strobe, busy, sample_ready}
    } vec_t;

    vec_t        tbl[14];
    logic [11:0] got;
    int          cnt_a, cnt_b;

    initial begin
        smp.sample_valid = 1'b0;
        smp.sample_in    = '0;

        // Preloaded 12'hA5C sent as one framed word, then stream stops.
        tbl[0]  = '{1'b0, 1'b1, 12'hA5C, 5'b00000};
        tbl[1]  = '{1'b1, 1'b0, 12'h000, 5'b11111};
        tbl[2]  = '{1'b1, 1'b0, 12'h000, 5'b01011};
        tbl[3]  = '{1'b1, 1'b0, 12'h000, 5'b11011};
        tbl[4]  = '{1'b1, 1'b0, 12'h000, 5'b01011};
        tbl[5]  = '{1'b1, 1'b0, 12'h000, 5'b01011};
        tbl[6]  = '{1'b1, 1'b0, 12'h000, 5'b11011};
        tbl[7]  = '{1'b1, 1'b0, 12'h000, 5'b00011};
        tbl[8]  = '{1'b1, 1'b0, 12'h000, 5'b10011};
        tbl[9]  = '{1'b1, 1'b0, 12'h000, 5'b10011};
        tbl[10] = '{1'b1, 1'b0, 12'h000, 5'b10011};
        tbl[11] = '{1'b1, 1'b0, 12'h000, 5'b00011};
        tbl[12] = '{1'b1, 1'b0, 12'h000, 5'b00011};
        tbl[13] = '{1'b0, 1'b0, 12'h000, 5'b00001};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].valid, tbl[i].din);
            check($sformatf("table_row%0d", i), 32'(dut_vec() >> 8), 32'(tbl[i].exp));
        end
        check("table_underrun", 32'(underrun_count), 32'd0);

        // Three idle words with no samples offered.
        do_reset();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 36; i++) begin
            step(1'b1, 1'b0, 12'h000);
            cnt_a += int'(adc_data);
            cnt_b += int'(word_strobe);
        end
        check("idle_word_ones", 32'(cnt_a), 32'd0);
        check("idle_word_strobes", 32'(cnt_b), 32'd3);
        step(1'b0, 1'b0, 12'h000);
        check("underrun_3", 32'(underrun_count), 32'd3);
        check("idle_after_stop", 32'({busy, adc_frame}), 32'd0);

        // Sample offered exactly on a load edge bypasses the hold register.
        do_reset();
        repeat (12) step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'h123);
        check("bypass_ready", 32'(smp.sample_ready), 32'd1);
        check("bypass_strobe", 32'(word_strobe), 32'd1);
        got[11] = adc_data;
        for (int i = 1; i < 12; i++) begin
            step(1'b1, 1'b0, 12'h000);
            got[11-i] = adc_data;
        end
        check("bypass_word", 32'(got), 32'h123);
        check("bypass_underrun", 32'(underrun_count), 32'd1);

        // Enable dropped mid-word: word still completes.
        do_reset();
        repeat (5) step(1'b1, 1'b0, 12'h000);
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 12'h000);
            cnt_a += int'(busy);
        end
        check("drop_busy_cycles", 32'(cnt_a), 32'd7);
        step(1'b0, 1'b0, 12'h000);
        check("drop_then_idle", 32'({busy, adc_frame}), 32'd0);

        // Asynchronous reset at position 7.
        do_reset();
        repeat (8) step(1'b1, 1'b0, 12'h000);
        #2;
        RESET_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_vec()), 32'(13'b0000_1_00000000));
        model_reset();
        @(posedge clk);
        #1;
        RESET_n = 1'b1;
        step(1'b1, 1'b0, 12'h000);
        check("restart_pos0", 32'({word_strobe, adc_frame, busy}), 32'b111);
        check("restart_model", 32'(dut_vec()), 32'(model_vec()));

        // Underrun counter saturates.
        do_reset();
        repeat (260 * 12) step(1'b1, 1'b0, 12'h000);
        check("underrun_saturate", 32'(underrun_count), 32'd255);

`ifdef ADC_SERIAL_TX_TEST_PATTERN_EN
        do_reset();
        test_mode = 1'b1;
        #1;
        check("ramp_ready_low", 32'(smp.sample_ready), 32'd0);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 12; i++) begin
                step(1'b1, 1'b1, 12'hFFF);
                got[11-i] = adc_data;
            end
            check($sformatf("ramp_word%0d", w), 32'(got), 32'(w));
        end
        check("ramp_underrun", 32'(underrun_count), 32'd0);
        test_mode = 1'b0;
`endif

        // Randomized run against the model, alternating busy and sparse enable phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit vl;
            if ((i / 300) % 2 == 0) en = ($urandom_range(0, 9) != 0);
            else                    en = ($urandom_range(0, 2) == 0);
            vl = ($urandom_range(0, 11) < 2);
            step(en, vl, 12'($urandom));
            check("random", 32'(dut_vec()), 32'(model_vec()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
